vending_credit_fsm: RTL and testbench

Downstream consumer of the UART receiver in the vending machine: it takes each received ASCII byte (with a one-cycle valid strobe) and interprets it as a coin insertion, product selection or refund request. It keeps the running credit, checks prices, and drives a timed dispense level plus a change report. It is the only block that holds money state.

---
 rtl/vending_pkg.sv | 28 ++
 rtl/hold_timer.sv | 34 +++
 rtl/vending_credit_fsm.sv | 151 +++++++++++++++
 tb/tb_vending_credit_fsm.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// Shared constants for the vending credit logic: ASCII command bytes,
// item codes and the controller state encoding.
package vending_pkg;

    localparam logic [7:0] CMD_NICKEL  = 8'h6E;
    localparam logic [7:0] CMD_DIME    = 8'h64;
    localparam logic [7:0] CMD_QUARTER = 8'h71;
    localparam logic [7:0] CMD_SEL_A   = 8'h61;
    localparam logic [7:0] CMD_SEL_B   = 8'h62;
    localparam logic [7:0] CMD_SEL_C   = 8'h63;
    localparam logic [7:0] CMD_REFUND  = 8'h72;

    localparam logic [1:0] ITEM_NONE = 2'd0;
    localparam logic [1:0] ITEM_A    = 2'd1;
    localparam logic [1:0] ITEM_B    = 2'd2;
    localparam logic [1:0] ITEM_C    = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    function automatic logic is_command(input logic [7:0] b);
        return b inside {CMD_NICKEL, CMD_DIME, CMD_QUARTER,
                         CMD_SEL_A, CMD_SEL_B, CMD_SEL_C, CMD_REFUND};
    endfunction

endpackage

// File: rtl/hold_timer.sv
// Loadable down-counter timing the dispense hold; done pulses on the
// last cycle of a HOLD_CYCLES-long window that begins the edge after start.
module hold_timer #(
    parameter int HOLD_CYCLES = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic done
);
    localparam int W = $clog2(HOLD_CYCLES + 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = W'(HOLD_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == W'(1));

endmodule

// File: rtl/vending_credit_fsm.sv
// Interprets received ASCII bytes as coins, selections and refunds; owns the
// credit balance and drives the timed dispense level and change report.
module vending_credit_fsm
    import vending_pkg::*;
#(
    parameter int PRICE_A     = 50,
    parameter int PRICE_B     = 75,
    parameter int PRICE_C     = 100,
    parameter int MAX_CREDIT  = 200,
    parameter int HOLD_CYCLES = 100_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] credit,
    output logic       dispense,
    output logic [1:0] item,
    output logic [7:0] change,
    output logic       change_valid,
    output logic       reject,
    output logic       busy
);
    state_e     state_q, state_d;
    logic [7:0] credit_q, credit_d;
    logic [7:0] change_q, change_d;
    logic       change_valid_q, change_valid_d;
    logic       reject_q, reject_d;
    logic       dispense_q, dispense_d;
    logic [1:0] item_q, item_d;
    logic       busy_q, busy_d;

    logic       timer_start;
    logic       timer_done;
    logic [8:0] coin_value;
    logic [8:0] coin_sum;
    logic [7:0] price;
    logic [1:0] sel_code;

    hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold_timer (
        .clk   (clk),
        .reset (reset),
        .start (timer_start),
        .done  (timer_done)
    );

    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        change_d       = change_q;
        change_valid_d = 1'b0;
        reject_d       = 1'b0;
        dispense_d     = dispense_q;
        item_d         = item_q;
        timer_start    = 1'b0;
        coin_value     = 9'd0;
        price          = 8'd0;
        sel_code       = ITEM_NONE;

        case (rx_data)
            CMD_NICKEL:  coin_value = 9'd5;
            CMD_DIME:    coin_value = 9'd10;
            CMD_QUARTER: coin_value = 9'd25;
            default:     coin_value = 9'd0;
        endcase
        case (rx_data)
            CMD_SEL_A: begin price = 8'(PRICE_A); sel_code = ITEM_A; end
            CMD_SEL_B: begin price = 8'(PRICE_B); sel_code = ITEM_B; end
            CMD_SEL_C: begin price = 8'(PRICE_C); sel_code = ITEM_C; end
            default:   begin price = 8'd0;        sel_code = ITEM_NONE; end
        endcase
        // Ninth bit keeps an overflowing coin from wrapping below the ceiling.
        coin_sum = {1'b0, credit_q} + coin_value;

        case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    if (coin_value != 9'd0) begin
                        if (coin_sum > 9'(MAX_CREDIT)) begin
                            reject_d = 1'b1;
                        end else begin
                            credit_d = coin_sum[7:0];
                        end
                    end else if (sel_code != ITEM_NONE) begin
                        if (credit_q >= price) begin
                            credit_d       = 8'd0;
                            change_d       = credit_q - price;
                            change_valid_d = 1'b1;
                            dispense_d     = 1'b1;
                            item_d         = sel_code;
                            timer_start    = 1'b1;
                            state_d        = ST_HOLD;
                        end else begin
                            reject_d = 1'b1;
                        end
                    end else if (rx_data == CMD_REFUND && credit_q != 8'd0) begin
                        change_d       = credit_q;
                        change_valid_d = 1'b1;
                        credit_d       = 8'd0;
                    end
                end
            end
            ST_HOLD: begin
                if (rx_valid && is_command(rx_data)) begin
                    reject_d = 1'b1;
                end
                if (timer_done) begin
                    dispense_d = 1'b0;
                    item_d     = ITEM_NONE;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_HOLD);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            credit_q       <= 8'd0;
            change_q       <= 8'd0;
            change_valid_q <= 1'b0;
            reject_q       <= 1'b0;
            dispense_q     <= 1'b0;
            item_q         <= ITEM_NONE;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            change_q       <= change_d;
            change_valid_q <= change_valid_d;
            reject_q       <= reject_d;
            dispense_q     <= dispense_d;
            item_q         <= item_d;
            busy_q         <= busy_d;
        end
    end

    assign credit       = credit_q;
    assign dispense     = dispense_q;
    assign item         = item_q;
    assign change       = change_q;
    assign change_valid = change_valid_q;
    assign reject       = reject_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_vending_credit_fsm.sv
// Bench for vending_credit_fsm: directed scenarios plus random byte traffic,
// all checked against a money-level reference model held in integers.
module tb_vending_credit_fsm;

    localparam int HOLD = 8;
    localparam int MAXC = 200;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [7:0] credit;
    logic       dispense;
    logic [1:0] item;
    logic [7:0] change;
    logic       change_valid;
    logic       reject;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state, in plain cents and cycles.
    int m_credit = 0;
    int m_change = 0;
    int m_item = 0;
    int m_hold_left = 0;
    bit m_disp = 0;
    bit m_cv = 0;
    bit m_rej = 0;

    vending_credit_fsm #(
        .PRICE_A(50), .PRICE_B(75), .PRICE_C(100),
        .MAX_CREDIT(MAXC), .HOLD_CYCLES(HOLD)
    ) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .credit(credit), .dispense(dispense), .item(item), .change(change),
        .change_valid(change_valid), .reject(reject), .busy(busy)
    );

    always #5 clk = ~clk;

    wire [21:0] dut_vec = {credit, dispense, item, change, change_valid, reject, busy};

    function automatic logic [21:0] exp_vec();
        return {8'(m_credit), m_disp, 2'(m_item), 8'(m_change), m_cv, m_rej,
                (m_hold_left > 0)};
    endfunction

    function automatic int coin_of(input logic [7:0] b);
        case (b)
            8'h6E:   return 5;
            8'h64:   return 10;
            8'h71:   return 25;
            default: return 0;
        endcase
    endfunction

    function automatic int price_of(input logic [7:0] b);
        case (b)
            8'h61:   return 50;
            8'h62:   return 75;
            8'h63:   return 100;
            default: return 0;
        endcase
    endfunction

    task automatic model_step(input logic v, input logic [7:0] d, input logic r);
        int sum;
        if (!r) begin
            m_credit = 0; m_change = 0; m_item = 0; m_hold_left = 0;
            m_disp = 0; m_cv = 0; m_rej = 0;
            return;
        end
        m_cv = 0;
        m_rej = 0;
        if (m_hold_left > 0) begin
            if (v && (coin_of(d) > 0 || price_of(d) > 0 || d == 8'h72)) m_rej = 1;
            m_hold_left--;
            if (m_hold_left == 0) begin
                m_disp = 0;
                m_item = 0;
            end
        end else if (v) begin
            if (coin_of(d) > 0) begin
                sum = m_credit + coin_of(d);
                if (sum > MAXC) m_rej = 1;
                else m_credit = sum;
            end else if (price_of(d) > 0) begin
                if (m_credit >= price_of(d)) begin
                    m_change = m_credit - price_of(d);
                    m_credit = 0;
                    m_cv = 1;
                    m_disp = 1;
                    m_item = int'(d) - 8'h60;
                    m_hold_left = HOLD;
                end else begin
                    m_rej = 1;
                end
            end else if (d == 8'h72 && m_credit > 0) begin
                m_change = m_credit;
                m_credit = 0;
                m_cv = 1;
            end
        end
    endtask

    // Called at a negedge; applies one cycle of input and returns at the next negedge.
    task automatic drive(input logic v, input logic [7:0] d, input logic r);
        reset = r;
        rx_valid = v;
        rx_data = d;
        @(posedge clk);
        model_step(v, d, r);
        @(negedge clk);
        rx_valid = 1'b0;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        drive(1'b1, 8'h71, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        n_cmp++;
        if (dut_vec !== 22'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h required 000000", dut_vec);
        end
    endtask

    task automatic test_coins();
        drive(1'b1, 8'h71, 1'b1);
        n_cmp++;
        if (credit !== 8'd25 || reject !== 1'b0 || change_valid !== 1'b0) begin
            n_err++;
            $display("FAIL coins_first_q: credit=%0d rej=%b cv=%b required 25/0/0",
                     credit, reject, change_valid);
        end
        drive(1'b1, 8'h71, 1'b1);
        n_cmp++;
        if (credit !== 8'd50 || reject !== 1'b0 || change_valid !== 1'b0) begin
            n_err++;
            $display("FAIL coins_second_q: credit=%0d rej=%b cv=%b required 50/0/0",
                     credit, reject, change_valid);
        end
    endtask

    task automatic test_vend_a();
        int disp_cycles = 0;
        int busy_cycles = 0;
        int bad_item = 0;
        drive(1'b1, 8'h61, 1'b1);
        n_cmp++;
        if (change_valid !== 1'b1 || change !== 8'd0 || credit !== 8'd0 || item !== 2'd1) begin
            n_err++;
            $display("FAIL vend_a_start: cv=%b change=%0d credit=%0d item=%0d required 1/0/0/1",
                     change_valid, change, credit, item);
        end
        for (int i = 0; i < HOLD + 4; i++) begin
            if (dispense) disp_cycles++;
            if (busy) busy_cycles++;
            if (dispense && item !== 2'd1) bad_item++;
            if (!dispense && item !== 2'd0) bad_item++;
            drive(1'b0, 8'h00, 1'b1);
        end
        n_cmp++;
        if (disp_cycles != HOLD || busy_cycles != HOLD || bad_item != 0) begin
            n_err++;
            $display("FAIL vend_a_hold: dispense=%0d busy=%0d bad_item=%0d required %0d/%0d/0",
                     disp_cycles, busy_cycles, bad_item, HOLD, HOLD);
        end
    endtask

    task automatic test_reject_refund();
        drive(1'b1, 8'h71, 1'b1);
        drive(1'b1, 8'h6E, 1'b1);
        drive(1'b1, 8'h62, 1'b1);
        n_cmp++;
        if (reject !== 1'b1 || credit !== 8'd30 || change_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reject_b: rej=%b credit=%0d cv=%b required 1/30/0",
                     reject, credit, change_valid);
        end
        drive(1'b1, 8'h72, 1'b1);
        n_cmp++;
        if (change_valid !== 1'b1 || change !== 8'd30 || credit !== 8'd0 || reject !== 1'b0) begin
            n_err++;
            $display("FAIL refund_30: cv=%b change=%0d credit=%0d rej=%b required 1/30/0/0",
                     change_valid, change, credit, reject);
        end
        drive(1'b1, 8'h72, 1'b1);
        n_cmp++;
        if (change_valid !== 1'b0 || reject !== 1'b0 || change !== 8'd30) begin
            n_err++;
            $display("FAIL refund_empty: cv=%b rej=%b change=%0d required 0/0/30",
                     change_valid, reject, change);
        end
    endtask

    task automatic test_max_credit();
        int disp_cycles = 0;
        for (int i = 0; i < 8; i++) drive(1'b1, 8'h71, 1'b1);
        drive(1'b1, 8'h6E, 1'b1);
        n_cmp++;
        if (reject !== 1'b1 || credit !== 8'd200) begin
            n_err++;
            $display("FAIL over_max: rej=%b credit=%0d required 1/200", reject, credit);
        end
        drive(1'b1, 8'h63, 1'b1);
        n_cmp++;
        if (change !== 8'd100 || change_valid !== 1'b1 || item !== 2'd3) begin
            n_err++;
            $display("FAIL vend_c: change=%0d cv=%b item=%0d required 100/1/3",
                     change, change_valid, item);
        end
        for (int i = 0; i < HOLD + 3; i++) begin
            if (dispense && item === 2'd3) disp_cycles++;
            drive(1'b0, 8'h00, 1'b1);
        end
        n_cmp++;
        if (disp_cycles != HOLD) begin
            n_err++;
            $display("FAIL vend_c_hold: dispense cycles=%0d required %0d", disp_cycles, HOLD);
        end
    endtask

    task automatic test_hold_commands();
        int rejects = 0;
        int guard = 0;
        drive(1'b1, 8'h71, 1'b1);
        drive(1'b1, 8'h71, 1'b1);
        drive(1'b1, 8'h61, 1'b1);
        drive(1'b1, 8'h71, 1'b1);
        if (reject) rejects++;
        drive(1'b1, 8'h78, 1'b1);
        if (reject) rejects++;
        n_cmp++;
        if (rejects != 1 || credit !== 8'd0) begin
            n_err++;
            $display("FAIL hold_cmds: rejects=%0d credit=%0d required 1/0", rejects, credit);
        end
        while (busy && guard < 4 * HOLD) begin
            drive(1'b0, 8'h00, 1'b1);
            guard++;
        end
        n_cmp++;
        if (busy) begin
            n_err++;
            $display("FAIL hold_exit: busy=%b still high after %0d cycles required 0", busy, guard);
        end
        drive(1'b1, 8'h64, 1'b1);
        n_cmp++;
        if (credit !== 8'd10 || reject !== 1'b0) begin
            n_err++;
            $display("FAIL first_idle_byte: credit=%0d rej=%b required 10/0", credit, reject);
        end
    endtask

    task automatic test_reset_mid_hold();
        drive(1'b1, 8'h71, 1'b1);
        drive(1'b1, 8'h71, 1'b1);
        drive(1'b1, 8'h61, 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        drive(1'b1, 8'h6E, 1'b0);
        n_cmp++;
        if (dispense !== 1'b0 || item !== 2'd0 || busy !== 1'b0 || credit !== 8'd0) begin
            n_err++;
            $display("FAIL reset_mid_hold: disp=%b item=%0d busy=%b credit=%0d required 0/0/0/0",
                     dispense, item, busy, credit);
        end
        drive(1'b1, 8'h6E, 1'b1);
        n_cmp++;
        if (credit !== 8'd5) begin
            n_err++;
            $display("FAIL after_reset_n: credit=%0d required 5", credit);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 8'h71, 1'b1);
        drive(1'b1, 8'h64, 1'b1);
        drive(1'b1, 8'h6E, 1'b1);
        n_cmp++;
        if (dut_vec !== exp_vec()) begin
            n_err++;
            $display("FAIL back_to_back: got %h required %h", dut_vec, exp_vec());
        end
        drive(1'b1, 8'h72, 1'b1);
        n_cmp++;
        if (dut_vec !== exp_vec()) begin
            n_err++;
            $display("FAIL back_to_back_refund: got %h required %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_random();
        logic [7:0] cmds [8];
        logic [7:0] b;
        int k;
        cmds = '{8'h6E, 8'h64, 8'h71, 8'h71, 8'h61, 8'h62, 8'h63, 8'h72};
        for (int i = 0; i < 600; i++) begin
            k = $urandom_range(0, 9);
            b = (k < 8) ? cmds[k] : 8'($urandom_range(0, 255));
            drive(1'($urandom_range(0, 3) != 0), b, 1'($urandom_range(0, 99) != 0));
            n_cmp++;
            if (dut_vec !== exp_vec() || (change_valid && reject)) begin
                n_err++;
                $display("FAIL random_step %0d: got %h required %h (cv&rej=%b)",
                         i, dut_vec, exp_vec(), change_valid & reject);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_coins();
        test_vend_a();
        test_reject_refund();
        test_max_credit();
        test_hold_commands();
        test_reset_mid_hold();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
